// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu execute unit: operation codes,
// FSM state encoding and operation-class decode helpers.
package alu_pkg;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_SLL    = 5'd2;
   localparam logic [4:0] OP_SLT    = 5'd3;
   localparam logic [4:0] OP_SLTU   = 5'd4;
   localparam logic [4:0] OP_XOR    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_OR     = 5'd8;
   localparam logic [4:0] OP_AND    = 5'd9;
   localparam logic [4:0] OP_PASSB  = 5'd10;
   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [4:0] OP_DIV    = 5'd20;
   localparam logic [4:0] OP_DIVU   = 5'd21;
   localparam logic [4:0] OP_REM    = 5'd22;
   localparam logic [4:0] OP_REMU   = 5'd23;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } mdu_mode_e;

   function automatic logic is_mul(input logic [4:0] op);
      return op[4:2] == 3'b100;
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return op[4:2] == 3'b101;
   endfunction

   function automatic logic is_rem(input logic [4:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_signed_div(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fixup on the last step.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  mdu_mode_e       mode_i,
   input  logic [4:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] res_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   mdu_mode_e         mode_q, mode_d;
   logic              sel_q, sel_d;
   logic              neg_q, neg_d;

   logic              neg_a_s, neg_b_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s;
   logic [XLEN:0]     mul_sum_s;
   logic [XLEN:0]     div_part_s, div_diff_s;
   logic              div_ge_s;
   logic [XLEN-1:0]   div_rem_s;
   logic [2*XLEN-1:0] step_s, full_s;
   logic [XLEN-1:0]   pick_s;

   // Operand sign handling at start: MULHSU treats only A as signed.
   always_comb begin
      neg_a_s = a_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU) || is_signed_div(op_i));
      neg_b_s = b_i[XLEN-1] & ((op_i == OP_MULH) || is_signed_div(op_i));
      mag_a_s = neg_a_s ? -a_i : a_i;
      mag_b_s = neg_b_s ? -b_i : b_i;
   end

   // One multiply or divide step plus the final signed result of that step.
   always_comb begin
      mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
      div_part_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff_s = div_part_s - {1'b0, opnd_q};
      div_ge_s   = div_part_s >= {1'b0, opnd_q};
      div_rem_s  = div_ge_s ? div_diff_s[XLEN-1:0] : div_part_s[XLEN-1:0];
      if (mode_q == MODE_MUL) begin
         step_s = {mul_sum_s, acc_q[XLEN-1:1]};
         full_s = neg_q ? -step_s : step_s;
      end else begin
         step_s = {div_rem_s, acc_q[XLEN-2:0], div_ge_s};
         full_s = step_s;
      end
      // Upper half is the high product word for MULH* and the remainder for REM*.
      pick_s = sel_q ? full_s[2*XLEN-1:XLEN] : full_s[XLEN-1:0];
      res_o  = ((mode_q == MODE_DIV) && neg_q) ? -pick_s : pick_s;
   end

   // Load on start, iterate while the counter is non-zero.
   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      opnd_d = opnd_q;
      mode_d = mode_q;
      sel_d  = sel_q;
      neg_d  = neg_q;
      if (start_i) begin
         cnt_d  = CNT_W'(XLEN);
         mode_d = mode_i;
         if (mode_i == MODE_MUL) begin
            acc_d  = {{XLEN{1'b0}}, mag_b_s};
            opnd_d = mag_a_s;
            sel_d  = (op_i != OP_MUL);
            neg_d  = neg_a_s ^ neg_b_s;
         end else begin
            acc_d  = {{XLEN{1'b0}}, mag_a_s};
            opnd_d = mag_b_s;
            sel_d  = is_rem(op_i);
            neg_d  = is_rem(op_i) ? neg_a_s : (neg_a_s ^ neg_b_s);
         end
      end else if (cnt_q != {CNT_W{1'b0}}) begin
         acc_d = step_s;
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));

   // Iteration state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= {CNT_W{1'b0}};
         acc_q  <= {(2*XLEN){1'b0}};
         opnd_q <= {XLEN{1'b0}};
         mode_q <= MODE_MUL;
         sel_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         mode_q <= mode_d;
         sel_q  <= sel_d;
         neg_q  <= neg_d;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// RV32IM execute unit: single-cycle ALU, control FSM and result register,
// with multiply/divide delegated to the shared iterative datapath.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int SH_W = $clog2(XLEN);

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [4:0]      op5_s;
   logic            op_ok_s;
   logic [SH_W-1:0] sh_s;
   logic [XLEN-1:0] alu_s;
   logic [XLEN-1:0] min_s;
   logic            start_s;
   mdu_mode_e       mode_s;
   logic            iter_done_s;
   logic [XLEN-1:0] iter_res_s;

   // Codes with any bit set above the 5-bit field are treated as unknown.
   assign op5_s   = op[4:0];
   assign op_ok_s = (op == OP_W'(op5_s));
   assign sh_s    = src_b[SH_W-1:0];
   assign min_s   = {1'b1, {(XLEN-1){1'b0}}};

   // Single-cycle ALU on the incoming request.
   always_comb begin
      alu_s = {XLEN{1'b0}};
      if (op_ok_s) begin
         case (op5_s)
            OP_ADD:   alu_s = src_a + src_b;
            OP_SUB:   alu_s = src_a - src_b;
            OP_SLL:   alu_s = src_a << sh_s;
            OP_SLT:   alu_s = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU:  alu_s = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_XOR:   alu_s = src_a ^ src_b;
            OP_SRL:   alu_s = src_a >> sh_s;
            OP_SRA:   alu_s = $unsigned($signed(src_a) >>> sh_s);
            OP_OR:    alu_s = src_a | src_b;
            OP_AND:   alu_s = src_a & src_b;
            OP_PASSB: alu_s = src_b;
            default:  alu_s = {XLEN{1'b0}};
         endcase
      end else begin
         alu_s = {XLEN{1'b0}};
      end
   end

   // Control FSM: accept, dispatch, divide fast paths, hold result until taken.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      start_s  = 1'b0;
      mode_s   = MODE_MUL;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (op_ok_s && is_mul(op5_s)) begin
                  start_s = 1'b1;
                  mode_s  = MODE_MUL;
                  state_d = ST_MUL;
               end else if (op_ok_s && is_div(op5_s)) begin
                  mode_s = MODE_DIV;
                  if (src_b == {XLEN{1'b0}}) begin
                     result_d = is_rem(op5_s) ? src_a : {XLEN{1'b1}};
                     state_d  = ST_DONE;
                  end else if (is_signed_div(op5_s) && (src_a == min_s) && (src_b == {XLEN{1'b1}})) begin
                     result_d = is_rem(op5_s) ? {XLEN{1'b0}} : src_a;
                     state_d  = ST_DONE;
                  end else begin
                     start_s = 1'b1;
                     state_d = ST_DIV;
                  end
               end else begin
                  result_d = alu_s;
                  state_d  = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (iter_done_s) begin
               result_d = iter_res_s;
               state_d  = ST_DONE;
            end else begin
               state_d = state_q;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   mdu_iter #(.XLEN(XLEN)) u_iter (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_s),
      .mode_i  (mode_s),
      .op_i    (op5_s),
      .a_i     (src_a),
      .b_i     (src_b),
      .done_o  (iter_done_s),
      .res_o   (iter_res_s)
   );

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= {XLEN{1'b0}};
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign result    = result_q;

endmodule
